uart_tx_cfg: RTL and testbench

Parametrised, buffered UART transmitter that replaces the fixed 8-bit serializer/parity/FSM/mux transmit path with a single configurable block. It accepts parallel words through a valid/ready handshake into an internal FIFO and serialises them LSB-first. Each frame has a start bit, DATA_WIDTH data bits, an optional even/odd parity bit, and one or two stop bits. An integrated bit-period counter sets the bit rate. The block sits between the system bus/register file and the TX pin.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types, constants and helpers for the configurable UART transmitter
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width needed to hold a word count of 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through synchronous FIFO feeding the transmitter
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with configurable width, parity, stop bits and bit rate
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               data_valid,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               data_ready,
    input  logic                               par_en,
    input  logic                               par_typ,
    input  logic                               stop2,
    input  logic [DIV_WIDTH-1:0]               clk_div,
    output logic                               tx_out,
    output logic                               busy,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);

    localparam int              BCW      = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic [DIV_WIDTH-1:0]  div_eff;

    assign div_eff    = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
    assign bit_end    = (cnt_q == '0);
    assign push       = data_valid && !fifo_full;
    assign data_ready = !fifo_full;
    assign busy       = (state_q != IDLE);
    assign tx_out     = tx_q;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state, bit timing, pop/config latch and registered line value
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        pop       = 1'b0;

        if (state_q != IDLE && !bit_end) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = div_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = div_q - 1'b1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = div_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BCW'(1);
                        cnt_d = div_q - 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a new frame: take the FIFO head and freeze this frame's settings
        if (pop) begin
            state_d   = START;
            shreg_d   = head;
            div_d     = div_eff;
            cnt_d     = div_eff - 1'b1;
            bit_d     = '0;
            par_en_d  = par_en;
            stop2_d   = stop2;
            par_bit_d = (^head) ^ (par_typ == PAR_ODD);
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset returns the line to idle-high immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        data_ready;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [15:0] clk_div;
    logic        tx_out;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    logic line_q [$];

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        logic [15:0] div;
        logic [63:0] frame;
        int          nbits;
    } vec_t;

    vec_t vecs [7];

    uart_tx_cfg #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .clk_div    (clk_div),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record tx_out on every falling edge while busy; called on a falling edge
    task automatic capture(input string name, input int max_cycles, output int len);
        int waited = 0;
        line_q.delete();
        len = 0;
        while (!busy && waited < max_cycles) begin
            @(negedge clk);
            waited++;
        end
        if (!busy) begin
            check({name, "_busy_rise"}, busy, 1);
            return;
        end
        while (busy && len < max_cycles) begin
            line_q.push_back(tx_out);
            len++;
            @(negedge clk);
        end
    endtask

    // Expected line: bit j of bits held for max(div,1) cycles
    task automatic check_line(input string name, input logic [63:0] bits, input int nbits,
                              input int div, input int len);
        int de;
        int bad;
        de  = (div == 0) ? 1 : div;
        bad = 0;
        check({name, "_len"}, len, nbits * de);
        for (int c = 0; c < len && c < nbits * de; c++) begin
            if (line_q[c] !== bits[c / de]) bad++;
        end
        check({name, "_line"}, bad, 0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int len;
        par_en     = v.pe;
        par_typ    = v.pt;
        stop2      = v.s2;
        clk_div    = v.div;
        data_valid = 1'b1;
        data_in    = v.data;
        @(negedge clk);
        check({name, "_cnt_push"}, fifo_count, 1);
        check({name, "_busy_pre"}, busy, 0);
        data_valid = 1'b0;
        @(negedge clk);
        check({name, "_busy_pop"}, busy, 1);
        check({name, "_tx_start"}, tx_out, 0);
        check({name, "_cnt_pop"}, fifo_count, 0);
        capture(name, 1000, len);
        check_line(name, v.frame, v.nbits, int'(v.div), len);
    endtask

    initial begin
        int         len;
        int         idx;
        logic       rdy_s;
        logic [7:0] words [6];
        logic [63:0] exp_bits;
        int         stray;

        // frame literals: bit 0 = start bit, then data LSB first, parity, stop(s)
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 64'(10'b1101001010),   10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'd4, 64'(11'b10101001010),  11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 16'd4, 64'(11'b11101001010),  11};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'd1, 64'(11'b11000000000),  11};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 16'd0, 64'(11'b11111111110),  11};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'd2, 64'(12'b111001111000), 12};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 16'd3, 64'(11'b11000000010),  11};

        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        clk_div    = 16'd4;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_count", fifo_count, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            repeat (2) @(negedge clk);
        end

        // back-to-back frames, one-cycle bits, two stop bits
        par_en     = 1'b0;
        stop2      = 1'b1;
        clk_div    = 16'd1;
        data_valid = 1'b1;
        data_in    = 8'h00;
        @(negedge clk);
        data_in    = 8'hFF;
        @(negedge clk);
        data_valid = 1'b0;
        capture("b2b", 200, len);
        check_line("b2b", 64'(22'b11111111110_11000000000), 22, 1, len);
        repeat (2) @(negedge clk);

        // fill the FIFO with continuous writes, then drain five frames
        stop2   = 1'b0;
        clk_div = 16'd8;
        words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            capture("fill", 1000, len);
            begin
                idx = 0;
                for (int cyc = 0; cyc < 12; cyc++) begin
                    data_valid = (idx < 5) || (cyc >= 6);
                    data_in    = words[(idx < 6) ? idx : 5];
                    rdy_s      = data_ready;
                    @(negedge clk);
                    if (rdy_s && data_valid) idx++;
                end
                check("fill_accepted", idx, 5);
                check("fill_ready", data_ready, 0);
                check("fill_count", fifo_count, 4);
                data_valid = 1'b0;
            end
        join
        exp_bits = '0;
        for (int f = 0; f < 5; f++) begin
            exp_bits[f * 10 +: 10] = {1'b1, words[f], 1'b0};
        end
        check_line("fill", exp_bits, 50, 8, len);
        repeat (2) @(negedge clk);

        // settings changed mid-frame apply only to the following frame
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        clk_div    = 16'd2;
        data_valid = 1'b1;
        data_in    = 8'h5A;
        @(negedge clk);
        data_in    = 8'hC3;
        @(negedge clk);
        data_valid = 1'b0;
        fork
            capture("cfgchg", 500, len);
            begin
                repeat (6) @(negedge clk);
                par_en = 1'b1;
                stop2  = 1'b1;
            end
        join
        check_line("cfgchg", 64'(22'b110110000110_1010110100), 22, 2, len);
        par_en = 1'b0;
        stop2  = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of a frame with two words queued
        clk_div    = 16'd4;
        data_valid = 1'b1;
        data_in    = 8'h12;
        @(negedge clk);
        data_in    = 8'h34;
        @(negedge clk);
        data_in    = 8'h56;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_busy_pre", busy, 1);
        check("rstmid_count_pre", fifo_count, 2);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_tx", tx_out, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_ready", data_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_out !== 1'b1) stray++;
        end
        check("rstmid_quiet", stray, 0);
        run_vec("recover", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
